// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Loader FSM encoding; values are fixed so state dumps read consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [31:0] END_SENTINEL   = 32'h0000_0000;

    // Byte address of a word index (words are 4-byte aligned).
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Shifts incoming bytes into a little-endian 32-bit word.
// word_ready pulses combinationally in the cycle the last byte of a word is
// accepted; word_next is the word including that byte.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word_next,
    output logic        word_ready
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;

    // Place each accepted byte in its lane; the counter wraps after the last lane.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_ready = 1'b0;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            byte_cnt_d = byte_cnt_q + 1'b1;
            word_ready = (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
        end
    end

    // Byte counter and word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_next = word_d;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as little-endian words at
// addresses 0,4,8,... while holding the CPU in reset. Loading stops after the
// all-zero sentinel word is written or after word index TAM is written.
// Optional: define IMEM_LOADER_CHECKSUM_EN for a running 32-bit word sum.
//
// Byte handshake: a byte is transferred on a rising clk edge where
// in_valid && in_ready; in_ready is high only in RECV, and the producer must
// hold in_data stable while in_valid is high and in_ready is low.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned TAM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic        cpu_hold,
    output logic [31:0] checksum
);

    localparam int unsigned IDX_W = (TAM > 0) ? $clog2(TAM + 1) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic             full_q, full_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic             launch;
    logic             accept;
    logic             word_ready;
    logic [31:0]      word_next;

    // A start is only honoured when no load is in progress.
    assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
    assign in_ready = (state_q == RECV);
    assign accept   = in_valid && in_ready;

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (launch),
        .accept     (accept),
        .in_data    (in_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

    // Next-state logic; the write strobe, address and data are registered so
    // they appear in the single WRITE cycle after the last byte.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        full_d     = full_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RECV;
                    word_idx_d = '0;
                    full_d     = 1'b0;
                end
            end
            RECV: begin
                if (word_ready) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = word_addr(32'(word_idx_q));
                    wr_data_d = word_next;
                end
            end
            WRITE: begin
                if (wr_data_q == END_SENTINEL) begin
                    state_d = DONE;
                end else if (word_idx_q == IDX_W'(TAM)) begin
                    state_d = DONE;
                    full_d  = 1'b1;
                end else begin
                    state_d    = RECV;
                    word_idx_d = word_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            full_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            full_q     <= full_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Sum every written word, sentinel included; cleared when a load starts.
    always_comb begin
        checksum_d = checksum_q;
        if (launch) begin
            checksum_d = '0;
        end else if (state_q == WRITE) begin
            checksum_d = checksum_q + wr_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    // A reset arriving during WRITE must not let the strobe through.
    assign wr_en    = wr_en_q && !reset;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == RECV) || (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign full     = full_q;
    assign cpu_hold = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (TAM=4).
module tb_imem_loader;

    localparam int unsigned TAM = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, busy, done, full, cpu_hold;
    logic [31:0] wr_addr, wr_data, checksum;

    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;
    int          checks = 0;
    int          failures = 0;

    imem_loader #(.TAM(TAM)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .cpu_hold (cpu_hold),
        .checksum (checksum)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%h data=%h required no write", wr_addr, wr_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== sb_exp) begin
                    failures++;
                    $display("FAIL write_match got addr=%h data=%h required addr=%h data=%h",
                             wr_addr, wr_data, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout got in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout got done=%b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, busy, done, full, cpu_hold} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags got rdy/wr/busy/done/full/hold=%b required 000001",
                     {in_ready, wr_en, busy, done, full, cpu_hold});
        end
        checks++;
        if ({wr_addr, wr_data, checksum} !== 96'd0) begin
            failures++;
            $display("FAIL reset_buses got addr=%h data=%h csum=%h required 0", wr_addr, wr_data, checksum);
        end
    endtask

    task automatic test_sentinel();
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd4, 32'h0000_0000});
        pulse_start();
        send_word(32'h0000_0013);
        send_word(32'h0000_0000);
        @(negedge clk);
        checks++;
        if ({wr_en, cpu_hold, done} !== 3'b110) begin
            failures++;
            $display("FAIL sentinel_write_cycle got wr/hold/done=%b required 110", {wr_en, cpu_hold, done});
        end
        @(negedge clk);
        checks++;
        if ({cpu_hold, done, full, busy} !== 4'b0100) begin
            failures++;
            $display("FAIL sentinel_done got hold/done/full/busy=%b required 0100", {cpu_hold, done, full, busy});
        end
        checks++;
        if (checksum !== (CSUM_EN ? 32'h0000_0013 : 32'h0)) begin
            failures++;
            $display("FAIL sentinel_checksum got %h required %h", checksum, CSUM_EN ? 32'h13 : 32'h0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sentinel_writes got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) exp_q.push_back({32'(i * 4), 32'h0050_0093 + 32'(i)});
        pulse_start();
        @(negedge clk);
        checks++;
        if ({done, cpu_hold, busy} !== 3'b011 || checksum !== 32'h0) begin
            failures++;
            $display("FAIL restart_from_done got done/hold/busy=%b csum=%h required 011 csum=0",
                     {done, cpu_hold, busy}, checksum);
        end
        for (int i = 0; i < 5; i++) send_word(32'h0050_0093 + 32'(i));
        wait_done("full");
        checks++;
        if ({done, full, cpu_hold} !== 3'b110) begin
            failures++;
            $display("FAIL full_flags got done/full/hold=%b required 110", {done, full, cpu_hold});
        end
        checks++;
        if (checksum !== (CSUM_EN ? 32'h0190_02E9 : 32'h0)) begin
            failures++;
            $display("FAIL full_checksum got %h required %h", checksum, CSUM_EN ? 32'h019002E9 : 32'h0);
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || done !== 1'b1) begin
                failures++;
                $display("FAIL full_extra_byte got in_ready=%b done=%b required 0 1", in_ready, done);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_writes got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_toggle_valid();
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        exp_q.push_back({32'd4, 32'h0000_0000});
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            @(posedge clk); #1;
        end
        send_word(32'h0000_0000);
        wait_done("toggle");
        checks++;
        if (exp_q.size() != 0 || full !== 1'b0) begin
            failures++;
            $display("FAIL toggle_writes got pending=%0d full=%b required 0 0", exp_q.size(), full);
        end
    endtask

    task automatic test_start_busy();
        exp_q.push_back({32'd0, 32'h1234_5678});
        exp_q.push_back({32'd4, 32'h0000_0000});
        pulse_start();
        send_byte(8'h78);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_busy_state got busy=%b done=%b required 1 0", busy, done);
        end
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_word(32'h0000_0000);
        wait_done("start_busy");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL start_busy_writes got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back({32'd0, 32'h1122_3344});
        pulse_start();
        send_word(32'h1122_3344);
        send_byte(8'hA1);
        send_byte(8'hA2);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_during got wr_en=%b hold=%b required 0 1", wr_en, cpu_hold);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, busy, done, full, cpu_hold} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_mid_flags got rdy/wr/busy/done/full/hold=%b required 000001",
                     {in_ready, wr_en, busy, done, full, cpu_hold});
        end
        checks++;
        if ({wr_addr, wr_data, checksum} !== 96'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_buses got addr=%h data=%h csum=%h pending=%0d required 0",
                     wr_addr, wr_data, checksum, exp_q.size());
        end
        exp_q.push_back({32'd0, 32'hCAFE_F00D});
        exp_q.push_back({32'd4, 32'h0000_0000});
        pulse_start();
        send_word(32'hCAFE_F00D);
        send_word(32'h0000_0000);
        wait_done("reset_mid");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_rewrite got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_checksum();
        exp_q.push_back({32'd0,  32'h0000_0001});
        exp_q.push_back({32'd4,  32'h0000_0002});
        exp_q.push_back({32'd8,  32'hFFFF_FFFF});
        exp_q.push_back({32'd12, 32'h0000_0000});
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0000);
        wait_done("checksum");
        checks++;
        if (checksum !== (CSUM_EN ? 32'h0000_0002 : 32'h0)) begin
            failures++;
            $display("FAIL checksum_value got %h required %h", checksum, CSUM_EN ? 32'h2 : 32'h0);
        end
        checks++;
        if (exp_q.size() != 0 || full !== 1'b0) begin
            failures++;
            $display("FAIL checksum_writes got pending=%0d full=%b required 0 0", exp_q.size(), full);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running required finished");
        $fatal(1, "watchdog");
    end

    // Test sequence and report
    initial begin
        test_reset();
        test_sentinel();
        test_full();
        test_toggle_valid();
        test_start_busy();
        test_reset_mid();
        test_checksum();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
